// File: rtl/cpu1_ocimem_arbiter.sv
// Shares CPU1's single-port OCI debug RAM between the JTAG debug path and the CPU
// debug-mode load/store port. It keeps a one-deep JTAG command and arbitrates round-robin.
module cpu1_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {
    StIdle, StJRd, StJRdw, StJWr, StCRd, StCRdw, StCWr
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic [DATA_W-1:0] jwdata_q;
  logic              jpend_q;
  logic              jpend_wr_q;
  logic              rr_last_jtag_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] mon_dreg_q;
  logic              monitor_ready_q;
  logic              monitor_error_q;

  logic j_busy, j_block, accept_a, accept_b, overrun, cpu_pend, grant_jtag;

  assign j_busy   = (state_q == StJRd) || (state_q == StJRdw) || (state_q == StJWr);
  assign j_block  = jpend_q || j_busy;
  assign accept_a = take_action_ocimem_a && !j_block;
  assign accept_b = take_action_ocimem_b && !take_action_ocimem_a && !j_block;
  assign overrun  = ((take_action_ocimem_a || take_action_ocimem_b) && j_block) ||
                    (take_action_ocimem_a && take_action_ocimem_b);
  // The CPU holds cpu_req until it sees the ack, so ignore it during the ack cycle.
  assign cpu_pend   = cpu_req && !cpu_ack_q;
  assign grant_jtag = jpend_q && (!cpu_pend || !rr_last_jtag_q);

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      jaddr_q         <= '0;
      jwdata_q        <= '0;
      jpend_q         <= 1'b0;
      jpend_wr_q      <= 1'b0;
      rr_last_jtag_q  <= 1'b0;
      cpu_ack_q       <= 1'b0;
      cpu_rdata_q     <= '0;
      mon_dreg_q      <= '0;
      monitor_ready_q <= 1'b1;
      monitor_error_q <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      if (overrun) begin
        monitor_error_q <= 1'b1;
      end
      if (accept_a) begin
        jaddr_q <= jdo[26 +: ADDR_W];
        if (jdo[34]) begin
          jpend_q         <= 1'b1;
          jpend_wr_q      <= 1'b0;
          monitor_ready_q <= 1'b0;
        end
      end
      if (accept_b) begin
        jwdata_q        <= jdo[3 +: DATA_W];
        jpend_q         <= 1'b1;
        jpend_wr_q      <= 1'b1;
        monitor_ready_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (grant_jtag) begin
            state_q <= jpend_wr_q ? StJWr : StJRd;
            jpend_q <= 1'b0;
            if (cpu_pend) begin
              rr_last_jtag_q <= 1'b1;
            end
          end else if (cpu_pend) begin
            state_q <= cpu_wr ? StCWr : StCRd;
            if (jpend_q) begin
              rr_last_jtag_q <= 1'b0;
            end
          end
        end
        StJRd: state_q <= StJRdw;
        StJRdw: begin
          mon_dreg_q      <= ram_rdata;
          monitor_ready_q <= 1'b1;
          state_q         <= StIdle;
        end
        StJWr: begin
          jaddr_q         <= jaddr_q + ADDR_W'(1);
          monitor_ready_q <= 1'b1;
          state_q         <= StIdle;
        end
        StCRd: state_q <= StCRdw;
        StCRdw: begin
          cpu_rdata_q <= ram_rdata;
          cpu_ack_q   <= 1'b1;
          state_q     <= StIdle;
        end
        StCWr: begin
          cpu_ack_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wr    = 1'b0;
    ram_wdata = '0;
    unique case (state_q)
      StJRd: ram_addr = jaddr_q;
      StJWr: begin
        ram_addr  = jaddr_q;
        ram_wr    = 1'b1;
        ram_wdata = jwdata_q;
      end
      StCRd: ram_addr = cpu_addr;
      StCWr: begin
        ram_addr  = cpu_addr;
        ram_wr    = 1'b1;
        ram_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = monitor_ready_q;
  assign monitor_error = monitor_error_q;

endmodule

// File: tb/tb_cpu1_ocimem_arbiter.sv
// Directed bench for cpu1_ocimem_arbiter: per-cycle vector table for the JTAG path,
// hand-written sequences for overrun, round-robin ties, CPU access and reset abort.
module tb_cpu1_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a, take_action_ocimem_b;
  logic [37:0] jdo;
  logic        cpu_req, cpu_wr;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu1_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .jdo                  (jdo),
    .cpu_req              (cpu_req),
    .cpu_wr               (cpu_wr),
    .cpu_addr             (cpu_addr),
    .cpu_wdata            (cpu_wdata),
    .cpu_ack              (cpu_ack),
    .cpu_rdata            (cpu_rdata),
    .ram_addr             (ram_addr),
    .ram_wr               (ram_wr),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  // Synchronous-read RAM model
  logic [31:0] mem [256];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) mem[k] <= '0;
    end else if (ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd);
    take_action_ocimem_a = 1'b1;
    jdo = {3'b000, rd, addr, 26'd0};
  endtask

  task automatic jtag_b(input logic [31:0] wd);
    take_action_ocimem_b = 1'b1;
    jdo = {3'b000, wd, 3'b000};
  endtask

  typedef struct {
    logic        a, b, rd;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        ready, wr, chk_addr;
    logic [7:0]  raddr;
    logic [31:0] rwd;
    logic        chk_mon;
    logic [31:0] mon;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic b, input logic rd,
                              input logic [7:0] addr, input logic [31:0] wd,
                              input logic ready, input logic wr, input logic chk_addr,
                              input logic [7:0] raddr, input logic [31:0] rwd,
                              input logic chk_mon, input logic [31:0] mon);
    vec_t v;
    v.a = a; v.b = b; v.rd = rd; v.addr = addr; v.wd = wd;
    v.ready = ready; v.wr = wr; v.chk_addr = chk_addr; v.raddr = raddr; v.rwd = rwd;
    v.chk_mon = chk_mon; v.mon = mon;
    return v;
  endfunction

  vec_t tbl [23];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             a     b     rd    addr   wdata          rdy   wr    chka  raddr  rwdata         chkm  mon
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h10, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 32'hDEADBEEF,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF,  1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 32'h12345678,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b1, 8'h11, 32'h12345678,  1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 32'hA5A5A5A5,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b1, 8'h12, 32'hA5A5A5A5,  1'b0, 32'h0);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 8'h10, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b1, 8'h10, 32'h0,         1'b0, 32'h0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'hDEADBEEF);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 8'hFF, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 8'h00, 32'h0BADF00D,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b1, 8'hFF, 32'h0BADF00D,  1'b0, 32'h0);
    tbl[19] = mk(1'b0, 1'b1, 1'b0, 8'h00, 32'h11112222,  1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 1'b1, 1'b1, 8'h00, 32'h11112222,  1'b0, 32'h0);
    tbl[22] = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0);

    reset = 1'b1;
    mem_clr = 1'b1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    cpu_req = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk1("rst_ready", monitor_ready, 1'b1);
    chk1("rst_error", monitor_error, 1'b0);
    chk1("rst_ack", cpu_ack, 1'b0);
    chk32("rst_rdata", cpu_rdata, 32'h0);
    chk32("rst_mondreg", MonDReg, 32'h0);
    chk1("rst_ram_wr", ram_wr, 1'b0);
    chk8("rst_ram_addr", ram_addr, 8'h00);
    chk32("rst_ram_wdata", ram_wdata, 32'h0);

    // JTAG write/read/wrap table, one row per clock
    for (int i = 0; i < 23; i++) begin
      next();
      if (tbl[i].a) jtag_a(tbl[i].addr, tbl[i].rd);
      if (tbl[i].b) jtag_b(tbl[i].wd);
      @(negedge clk);
      chk1($sformatf("v%0d_ready", i), monitor_ready, tbl[i].ready);
      chk1($sformatf("v%0d_error", i), monitor_error, 1'b0);
      chk1($sformatf("v%0d_ram_wr", i), ram_wr, tbl[i].wr);
      if (tbl[i].chk_addr) chk8($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].raddr);
      if (tbl[i].wr) chk32($sformatf("v%0d_ram_wdata", i), ram_wdata, tbl[i].rwd);
      if (tbl[i].chk_mon) chk32($sformatf("v%0d_mondreg", i), MonDReg, tbl[i].mon);
    end
    chk32("mem_10", mem[8'h10], 32'hDEADBEEF);
    chk32("mem_11", mem[8'h11], 32'h12345678);
    chk32("mem_12_autoinc", mem[8'h12], 32'hA5A5A5A5);
    chk32("mem_ff", mem[8'hFF], 32'h0BADF00D);
    chk32("mem_00_wrap", mem[8'h00], 32'h11112222);

    // Overrun: _b one cycle after an _a read is dropped and latches the error
    next(); jtag_a(8'h20, 1'b1); @(negedge clk);
    chk1("ovr_err_before", monitor_error, 1'b0);
    next(); jtag_b(32'h77777777); @(negedge clk);
    chk1("ovr_ready_low", monitor_ready, 1'b0);
    next(); @(negedge clk);
    chk1("ovr_err_set", monitor_error, 1'b1);
    chk1("ovr_no_write_rd", ram_wr, 1'b0);
    chk8("ovr_rd_addr", ram_addr, 8'h20);
    next(); @(negedge clk);
    chk1("ovr_no_write_rdw", ram_wr, 1'b0);
    next(); jtag_b(32'h99999999); @(negedge clk);
    chk32("ovr_mondreg", MonDReg, 32'h0);
    chk1("ovr_ready_back", monitor_ready, 1'b1);
    next(); @(negedge clk);
    chk1("ovr_ready_low2", monitor_ready, 1'b0);
    next(); @(negedge clk);
    chk1("ovr_wr2", ram_wr, 1'b1);
    chk8("ovr_wr2_addr_no_inc", ram_addr, 8'h20);
    chk32("ovr_wr2_data", ram_wdata, 32'h99999999);
    next(); @(negedge clk);
    chk1("ovr_err_sticky", monitor_error, 1'b1);
    chk32("ovr_mem_20", mem[8'h20], 32'h99999999);
    next(); reset = 1'b1; @(negedge clk);
    next(); reset = 1'b0; @(negedge clk);
    chk1("ovr_err_cleared", monitor_error, 1'b0);
    chk1("ovr_ready_reset", monitor_ready, 1'b1);

    // Tie after reset: JTAG wins, CPU follows
    next(); jtag_a(8'h11, 1'b1); @(negedge clk);
    next(); cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10; @(negedge clk);
    next(); @(negedge clk);
    chk8("rr1_jtag_first", ram_addr, 8'h11);
    next(); @(negedge clk);
    next(); @(negedge clk);
    chk32("rr1_mondreg", MonDReg, 32'h12345678);
    chk1("rr1_no_ack_yet", cpu_ack, 1'b0);
    next(); @(negedge clk);
    chk8("rr1_cpu_second", ram_addr, 8'h10);
    next(); @(negedge clk);
    chk1("rr1_ack_low", cpu_ack, 1'b0);
    next(); @(negedge clk);
    chk1("rr1_ack", cpu_ack, 1'b1);
    chk32("rr1_rdata", cpu_rdata, 32'hDEADBEEF);
    next(); cpu_req = 1'b0; @(negedge clk);
    chk1("rr1_ack_pulse", cpu_ack, 1'b0);

    // Second tie with JTAG granted last: CPU wins, JTAG follows
    next(); jtag_a(8'h12, 1'b1); @(negedge clk);
    next(); cpu_req = 1'b1; cpu_addr = 8'h11; @(negedge clk);
    next(); @(negedge clk);
    chk8("rr2_cpu_first", ram_addr, 8'h11);
    next(); @(negedge clk);
    next(); @(negedge clk);
    chk1("rr2_ack", cpu_ack, 1'b1);
    chk32("rr2_rdata", cpu_rdata, 32'h12345678);
    next(); cpu_req = 1'b0; @(negedge clk);
    chk8("rr2_jtag_second", ram_addr, 8'h12);
    next(); @(negedge clk);
    next(); @(negedge clk);
    chk32("rr2_mondreg", MonDReg, 32'hA5A5A5A5);
    chk1("rr2_ready", monitor_ready, 1'b1);

    // CPU write: C_WR next cycle, ack the cycle after
    next(); cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h30; cpu_wdata = 32'h5555AAAA;
    @(negedge clk);
    chk1("cwr_ack_idle", cpu_ack, 1'b0);
    next(); @(negedge clk);
    chk1("cwr_ram_wr", ram_wr, 1'b1);
    chk8("cwr_ram_addr", ram_addr, 8'h30);
    chk32("cwr_ram_wdata", ram_wdata, 32'h5555AAAA);
    next(); @(negedge clk);
    chk1("cwr_ack", cpu_ack, 1'b1);
    chk1("cwr_single_write", ram_wr, 1'b0);
    next(); cpu_req = 1'b0; cpu_wr = 1'b0; @(negedge clk);
    chk1("cwr_ack_pulse", cpu_ack, 1'b0);
    chk32("cwr_mem_30", mem[8'h30], 32'h5555AAAA);

    // Reset during C_RDW aborts the read with no ack
    next(); cpu_req = 1'b1; cpu_addr = 8'h30; @(negedge clk);
    next(); @(negedge clk);
    chk8("abort_rd_addr", ram_addr, 8'h30);
    next(); reset = 1'b1; @(negedge clk);
    next(); reset = 1'b0; cpu_req = 1'b0; @(negedge clk);
    chk1("abort_no_ack", cpu_ack, 1'b0);
    chk32("abort_rdata", cpu_rdata, 32'h0);
    chk32("abort_mondreg", MonDReg, 32'h0);
    chk1("abort_ready", monitor_ready, 1'b1);
    chk1("abort_error", monitor_error, 1'b0);
    chk1("abort_ram_wr", ram_wr, 1'b0);
    chk8("abort_ram_addr", ram_addr, 8'h00);
    chk32("abort_ram_wdata", ram_wdata, 32'h0);
    next(); @(negedge clk);
    chk1("abort_no_ack_later", cpu_ack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
